// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default frame constants, clog2 helper.
package uart_pkg;

    localparam int unsigned UART_NB_DATA = 8;
    localparam int unsigned UART_N_TICKS = 16;
    localparam int unsigned UART_N_STOP  = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_rx_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a selectable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_gen.sv
// Oversampling UART receiver with start-glitch rejection, frame-error and break handling.
// Define UART_RX_PARITY_EN to build in the parity bit stage and parity check.
module uart_rx_gen
    import uart_pkg::*;
#(
    parameter int unsigned NB_DATA    = UART_NB_DATA,
    parameter int unsigned N_TICKS    = UART_N_TICKS,
    parameter int unsigned N_STOP     = UART_N_STOP,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_frame_err,
    output logic               o_parity_err,
    output logic               o_busy
);

    localparam int unsigned TW = clog2(N_TICKS);
    localparam int unsigned BW = clog2(NB_DATA + 1);

    uart_rx_state_t      state, state_n;
    logic [TW-1:0]       tick_cnt, tick_n;
    logic [BW-1:0]       bit_cnt, bit_n;
    logic [NB_DATA-1:0]  shreg, shreg_n;
    logic                ferr, ferr_n;
    logic                done;
    logic                rxs;
    logic                mid_start, bit_end;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (i_clk),
        .rst_n (i_rst),
        .d     (i_rx),
        .q     (rxs)
    );

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = PARITY_ODD[0];
    logic perr, perr_n, perr_out;
`endif

    assign mid_start = i_tick && (tick_cnt == TW'(N_TICKS / 2 - 1));
    assign bit_end   = i_tick && (tick_cnt == TW'(N_TICKS - 1));
    assign o_busy    = (state != IDLE);

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        ferr_n  = ferr;
        done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n  = perr;
`endif
        // Counters advance only on ticks and are cleared explicitly at every sample point.
        if (i_tick && !bit_end) begin
            tick_n = tick_cnt + TW'(1);
        end
        case (state)
            IDLE: begin
                tick_n = '0;
                if (!rxs) begin
                    state_n = START;
                end
            end
            START: begin
                if (mid_start) begin
                    tick_n = '0;
                    bit_n  = '0;
                    ferr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_n = 1'b0;
`endif
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tick_n  = '0;
                    shreg_n = {rxs, shreg[NB_DATA-1:1]};
                    if (bit_cnt == BW'(NB_DATA - 1)) begin
                        bit_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tick_n  = '0;
                    perr_n  = rxs ^ (^shreg) ^ PAR_SENSE;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tick_n = '0;
                    ferr_n = ferr | ~rxs;
                    if (bit_cnt == BW'(N_STOP - 1)) begin
                        bit_n   = '0;
                        done    = 1'b1;
                        // A line still low here is a break; hold off until it idles.
                        state_n = rxs ? IDLE : BREAK;
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                    end
                end
            end
            BREAK: begin
                tick_n = '0;
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                tick_n  = '0;
                bit_n   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ferr     <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            ferr     <= ferr_n;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid <= done;
            if (done) begin
                o_data      <= shreg;
                o_frame_err <= ferr_n;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            perr     <= 1'b0;
            perr_out <= 1'b0;
        end else begin
            perr <= perr_n;
            if (done) begin
                perr_out <= perr_n;
            end
        end
    end

    assign o_parity_err = perr_out;
`else
    // Parity sense has no effect without the parity stage.
    assign o_parity_err = 1'b0 & PARITY_ODD[0];
`endif

endmodule

// File: tb/tb_uart_rx_gen.sv
// Self-checking bench for uart_rx_gen: directed scenarios plus random frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_gen;

    localparam int unsigned NB       = 8;
    localparam int unsigned NT       = 16;
    localparam int unsigned NS       = 1;
    localparam int unsigned PAR_ODD  = 0;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned BIT_CLKS = NT * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NP = 1;
`else
    localparam int unsigned NP = 0;
`endif
    // Ideal time from start-bit falling edge to the middle of the last stop bit.
    localparam int unsigned VALID_LAT = BIT_CLKS * (NB + NP + NS) + BIT_CLKS / 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick  = 1'b0;
    logic          rx    = 1'b1;
    logic [NB-1:0] o_data;
    logic          o_valid, o_frame_err, o_parity_err, o_busy;

    typedef struct {
        logic [NB-1:0] data;
        logic          ferr;
        logic          perr;
        int unsigned   t0;
    } frame_t;

    frame_t      exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    uart_rx_gen #(
        .NB_DATA    (NB),
        .N_TICKS    (NT),
        .N_STOP     (NS),
        .PARITY_ODD (PAR_ODD)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_tick       (tick),
        .i_rx         (rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // Expected result is derived from what goes on the wire, then the frame is serialised.
    task automatic send_frame(input logic [NB-1:0] d, input logic stop_bit, input logic par_flip);
        frame_t f;
        f.data = d;
        f.ferr = ~stop_bit;
`ifdef UART_RX_PARITY_EN
        f.perr = par_flip;
`else
        f.perr = 1'b0;
`endif
        f.t0 = cyc;
        exp_q.push_back(f);
        drive_bit(1'b0);
        for (int unsigned i = 0; i < NB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ PAR_ODD[0] ^ par_flip);
`endif
        for (int unsigned i = 0; i < NS; i++) drive_bit(stop_bit);
    endtask

    initial begin : monitor
        frame_t      f;
        int unsigned lat;
        forever begin
            @(negedge clk);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", o_valid, 1'b0);
                end else begin
                    f   = exp_q.pop_front();
                    lat = cyc - f.t0;
                    check("data", o_data, f.data);
                    check("frame_err", o_frame_err, f.ferr);
                    check("parity_err", o_parity_err, f.perr);
                    check("valid_latency",
                          (lat + 2 >= VALID_LAT && lat <= VALID_LAT + 6) ? VALID_LAT : lat,
                          VALID_LAT);
                end
            end
        end
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [NB-1:0] d;
        logic          stop_ok;
        logic          pflip;
        logic          busy_seen;

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data", o_data, '0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_frame_err", o_frame_err, 1'b0);
        check("rst_parity_err", o_parity_err, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        idle_bits(2);

        // Bits 1,1,0,0,1,0,1,0 LSB-first form 0x53.
        send_frame(8'h53, 1'b1, 1'b0);
        idle_bits(2);

        send_frame(8'h2B, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 1'b0);
        idle_bits(2);

        rx = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        busy_seen = o_busy;
        rx = 1'b1;
        check("glitch_busy_high", busy_seen, 1'b1);
        for (int unsigned i = 0; i < 9 * TICK_DIV; i++) begin
            @(negedge clk);
            if (!o_busy) break;
        end
        check("glitch_busy_low", o_busy, 1'b0);
        idle_bits(2);

        begin : held_low
            frame_t f;
            f.data = '0;
            f.ferr = 1'b1;
            f.perr = 1'b0;
            f.t0   = cyc;
            exp_q.push_back(f);
            rx = 1'b0;
            repeat (3 * (NB + NP + NS + 1)) drive_bit(1'b0);
            rx = 1'b1;
            repeat (8) @(negedge clk);
            check("break_busy_low", o_busy, 1'b0);
        end
        idle_bits(1);
        send_frame(8'h53, 1'b1, 1'b0);
        idle_bits(2);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h53, 1'b1, 1'b1);
        idle_bits(1);
        send_frame(8'h53, 1'b1, 1'b0);
        idle_bits(2);
`endif

        // Abort a frame after four data bits; nothing of it may surface.
        drive_bit(1'b0);
        for (int unsigned i = 0; i < 4; i++) drive_bit(i[0]);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_data", o_data, '0);
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_frame_err", o_frame_err, 1'b0);
        check("midrst_parity_err", o_parity_err, 1'b0);
        check("midrst_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        idle_bits(2);
        send_frame(8'h01, 1'b1, 1'b0);
        idle_bits(2);

        for (int unsigned n = 0; n < 24; n++) begin
            d       = NB'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            pflip   = ($urandom_range(0, 3) == 0);
            send_frame(d, stop_ok, pflip);
            idle_bits(stop_ok ? $urandom_range(0, 2) : $urandom_range(1, 2));
        end

        for (int unsigned i = 0; i < 4 * BIT_CLKS; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("pending_frames", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
